iwdg_seq_ctrl: RTL

//  Bus-master sequencer that configures, starts and services the IWDG block over its
//  cyc/stb/we/ack slave port. It replaces CPU-driven key sequences: on start it unlocks
//  (5555), writes RLR and PR, polls SR until idle, reloads (AAAA) and starts (CCCC).
//  It then issues refresh (AAAA) writes on request or from an internal timer.

---
 rtl/iwdg_seq_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/iwdg_seq_ctrl.sv
// Bus-master sequencer that unlocks, configures, starts and refreshes an IWDG over a cyc/stb/ack port.
// Optional build macro IWDG_AUTO_REFRESH_EN adds a free-running refresh timer active in RUN.
module iwdg_seq_ctrl #(
  parameter logic [31:0] BASE_ADR       = 32'h0100_0000,
  parameter int          ACK_TIMEOUT    = 16,
  parameter int          POLL_MAX       = 64,
  parameter int          REFRESH_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  cfg_pr,
  input  logic [11:0] cfg_rlr,
  input  logic        kick,
  output logic        busy,
  output logic        running,
  output logic        err,
  output logic [15:0] refresh_cnt,
  output logic [31:0] adr_m2s,
  output logic [15:0] dat_m2s,
  output logic        cyc_m2s,
  output logic        stb_m2s,
  output logic        we_m2s,
  input  logic [15:0] dat_s2m,
  input  logic        ack_s2m
);

  typedef enum logic [3:0] {
    S_IDLE, S_UNLOCK, S_WR_RLR, S_WR_PR, S_POLL,
    S_RELOAD, S_STARTK, S_RUN, S_REFRESH, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d, we_q, we_d, err_q, err_d, pend_q, pend_d;
  logic [31:0] adr_q, adr_d;
  logic [15:0] dat_q, dat_d, cnt_q, cnt_d, tmo_q, tmo_d, poll_q, poll_d;
  logic [2:0]  pr_q, pr_d;
  logic [11:0] rlr_q, rlr_d;

  logic        start_ok, bus_st, refresh_ack, tmr_req;
  logic [31:0] t_adr;
  logic [15:0] t_dat;
  logic        t_we;
  state_t      t_next;

  always_comb begin
    t_adr  = adr_q;
    t_dat  = dat_q;
    t_we   = 1'b0;
    t_next = state_q;
    case (state_q)
      S_UNLOCK:  begin t_adr = BASE_ADR;          t_dat = 16'h5555;        t_we = 1'b1; t_next = S_WR_RLR; end
      S_WR_RLR:  begin t_adr = BASE_ADR + 32'h8;  t_dat = {4'h0, rlr_q};   t_we = 1'b1; t_next = S_WR_PR;  end
      S_WR_PR:   begin t_adr = BASE_ADR + 32'h4;  t_dat = {13'h0, pr_q};   t_we = 1'b1; t_next = S_POLL;   end
      S_POLL:    begin t_adr = BASE_ADR + 32'hC;                                        t_next = S_RELOAD; end
      S_RELOAD:  begin t_adr = BASE_ADR;          t_dat = 16'hAAAA;        t_we = 1'b1; t_next = S_STARTK; end
      S_STARTK:  begin t_adr = BASE_ADR;          t_dat = 16'hCCCC;        t_we = 1'b1; t_next = S_RUN;    end
      S_REFRESH: begin t_adr = BASE_ADR;          t_dat = 16'hAAAA;        t_we = 1'b1; t_next = S_RUN;    end
      default:   ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    err_d       = err_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    poll_d      = poll_q;
    pr_d        = pr_q;
    rlr_d       = rlr_q;
    refresh_ack = 1'b0;
    start_ok    = start && (state_q == S_IDLE || state_q == S_RUN || state_q == S_ERR);
    bus_st      = !(state_q == S_IDLE || state_q == S_RUN || state_q == S_ERR);

    if (start_ok) begin
      state_d = S_UNLOCK;
      pr_d    = cfg_pr;
      rlr_d   = cfg_rlr;
      err_d   = 1'b0;
      cnt_d   = 16'h0;
      pend_d  = 1'b0;
      poll_d  = 16'h0;
    end else if (state_q == S_RUN) begin
      if (kick || pend_q || tmr_req) begin
        state_d = S_REFRESH;
        pend_d  = 1'b0;
      end
    end else if (bus_st) begin
      if (state_q == S_REFRESH && kick) pend_d = 1'b1;
      if (!cyc_q) begin
        // Entering a transaction state always leaves cyc low for one cycle first.
        cyc_d = 1'b1;
        adr_d = t_adr;
        dat_d = t_dat;
        we_d  = t_we;
        tmo_d = 16'h0;
      end else if (ack_s2m) begin
        cyc_d = 1'b0;
        if (state_q == S_POLL && dat_s2m[1:0] != 2'b00) begin
          if (poll_q == 16'(POLL_MAX - 1)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            poll_d = poll_q + 16'h1;
          end
        end else begin
          state_d = t_next;
        end
        if (state_q == S_RELOAD || state_q == S_REFRESH) begin
          cnt_d       = cnt_q + 16'h1;
          refresh_ack = 1'b1;
        end
      end else if (tmo_q == 16'(ACK_TIMEOUT - 1)) begin
        cyc_d   = 1'b0;
        err_d   = 1'b1;
        state_d = S_ERR;
      end else begin
        tmo_d = tmo_q + 16'h1;
      end
    end
  end

`ifdef IWDG_AUTO_REFRESH_EN
  logic [31:0] tmr_q, tmr_d;

  // Timer saturates at the request point until the refresh it causes is acknowledged.
  always_comb begin
    tmr_d = tmr_q;
    if (start_ok || refresh_ack)
      tmr_d = 32'h0;
    else if (state_q == S_RUN && tmr_q != 32'(REFRESH_PERIOD - 1))
      tmr_d = tmr_q + 32'h1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmr_q <= 32'h0;
    else      tmr_q <= tmr_d;
  end

  assign tmr_req = (state_q == S_RUN) && (tmr_q == 32'(REFRESH_PERIOD - 1));
`else
  assign tmr_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cyc_q   <= 1'b0;
      adr_q   <= 32'h0;
      dat_q   <= 16'h0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= 16'h0;
      tmo_q   <= 16'h0;
      poll_q  <= 16'h0;
      pr_q    <= 3'h0;
      rlr_q   <= 12'h0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      poll_q  <= poll_d;
      pr_q    <= pr_d;
      rlr_q   <= rlr_d;
    end
  end

  assign busy        = bus_st;
  assign running     = (state_q == S_RUN);
  assign err         = err_q;
  assign refresh_cnt = cnt_q;
  assign adr_m2s     = adr_q;
  assign dat_m2s     = dat_q;
  assign cyc_m2s     = cyc_q;
  assign stb_m2s     = cyc_q;
  assign we_m2s      = we_q;

endmodule
